// File: rtl/dec_stage_pipe_pkg.sv
// Shared encodings for the decode stage: size codes, immediate select codes
// and instruction field positions.
package dec_stage_pipe_pkg;

  // Store / load size codes; 2'b11 behaves as a word.
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  // Immediate select codes; 2'b11 behaves as zero-extend.
  localparam logic [1:0] IMM_ZERO = 2'b00;
  localparam logic [1:0] IMM_SIGN = 2'b01;
  localparam logic [1:0] IMM_LUI  = 2'b10;

  // Instruction field layout (5-bit register fields, 16-bit immediate).
  localparam int FIELD_W = 5;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 16;

endpackage

// File: rtl/dec_stage_pipe_if.sv
// Decode-stage bus: fetch-side inputs, write-back port and the ID/EX outputs.
interface dec_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
);
  logic              In_Valid;
  logic [31:0]       Instr;
  logic              RF_B_sel;
  logic [1:0]        Imm_sel;
  logic [1:0]        St_size;
  logic              Stall;
  logic              Flush;
  logic              WB_WrEn;
  logic [AW-1:0]     WB_Addr;
  logic              WB_Sel;
  logic [DATA_W-1:0] ALU_out;
  logic [DATA_W-1:0] MEM_out;
  logic [1:0]        Ld_size;
  logic              Ld_signed;
  logic              Out_Valid;
  logic [DATA_W-1:0] Out_RF_A;
  logic [DATA_W-1:0] Out_RF_B;
  logic [DATA_W-1:0] Out_Immed;
  logic [AW-1:0]     Out_Wr_Addr;
  logic [1:0]        Out_St_size;

  modport master (
    output In_Valid, Instr, RF_B_sel, Imm_sel, St_size, Stall, Flush,
           WB_WrEn, WB_Addr, WB_Sel, ALU_out, MEM_out, Ld_size, Ld_signed,
    input  Out_Valid, Out_RF_A, Out_RF_B, Out_Immed, Out_Wr_Addr, Out_St_size
  );

  modport slave (
    input  In_Valid, Instr, RF_B_sel, Imm_sel, St_size, Stall, Flush,
           WB_WrEn, WB_Addr, WB_Sel, ALU_out, MEM_out, Ld_size, Ld_signed,
    output Out_Valid, Out_RF_A, Out_RF_B, Out_Immed, Out_Wr_Addr, Out_St_size
  );
endinterface

// File: rtl/dec_stage_pipe_rf_bypass.sv
// Register file: two combinational read ports, one write port, r0 hard-wired
// to zero, and write-through bypass so a same-cycle write is seen by readers.
module dec_stage_pipe_rf_bypass #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  localparam int AW     = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [AW-1:0]     ra_a,
  input  logic [AW-1:0]     ra_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);
  logic [DATA_W-1:0] mem [REG_CNT];
  logic              wr_hit;

  // Writes to r0 are dropped here so every consumer sees the same rule.
  assign wr_hit = we && (wa != '0);

  // Storage update: reset clears every entry and wins over a pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) mem[i] <= '0;
    end else if (wr_hit) begin
      mem[wa] <= wd;
    end
  end

  // One identical read path per port: r0 first, then bypass, then storage.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] val;
    assign addr = (gi == 0) ? ra_a : ra_b;
    assign val  = (addr == '0)                 ? '0 :
                  (wr_hit && (wa == addr))      ? wd :
                                                  mem[addr];
  end

  assign rd_a = g_rd[0].val;
  assign rd_b = g_rd[1].val;

endmodule

// File: rtl/dec_stage_pipe.sv
// Decode stage: register read with bypass, immediate generation, store lane
// replication and load extension for write-back, behind a registered ID/EX
// boundary with valid/stall/flush control and operand refresh while stalled.
module dec_stage_pipe
  import dec_stage_pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32
) (
  input logic             Clk,
  input logic             Rst,
  dec_stage_pipe_if.slave bus
);
  localparam int AW = $clog2(REG_CNT);

  // Load extension of the write-back memory word.
  function automatic logic [DATA_W-1:0] ld_ext(input logic [DATA_W-1:0] m,
                                               input logic [1:0] sz,
                                               input logic sgn);
    logic [DATA_W-1:0] r;
    case (sz)
      SZ_BYTE: r = {{(DATA_W-8){sgn & m[7]}}, m[7:0]};
      SZ_HALF: r = {{(DATA_W-16){sgn & m[15]}}, m[15:0]};
      default: r = m;
    endcase
    return r;
  endfunction

  // Replicate the low byte/half across the full store bus.
  function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] b,
                                                  input logic [1:0] sz);
    logic [DATA_W-1:0] r;
    case (sz)
      SZ_BYTE: r = {(DATA_W/8){b[7:0]}};
      SZ_HALF: r = {(DATA_W/16){b[15:0]}};
      default: r = b;
    endcase
    return r;
  endfunction

  // lui is the sign-extended immediate shifted up by 16, which keeps the
  // imm[15] fill above bit 31 on wide datapaths.
  function automatic logic [DATA_W-1:0] imm_gen(input logic [15:0] imm,
                                                input logic [1:0] sel);
    logic [DATA_W-1:0] sx;
    logic [DATA_W-1:0] r;
    sx = {{(DATA_W-16){imm[15]}}, imm};
    case (sel)
      IMM_SIGN: r = sx;
      IMM_LUI:  r = sx << 16;
      default:  r = {{(DATA_W-16){1'b0}}, imm};
    endcase
    return r;
  endfunction

  logic [FIELD_W-1:0] rs_field, rt_field, rd_field;
  logic [IMM_W-1:0]   imm;
  logic [AW-1:0]      rs_addr, rt_addr, rb_addr;
  logic [DATA_W-1:0]  wb_data, rf_a, rf_b;
  logic               wb_we;
  logic               hit_rs, hit_rb;
  wire                unused_bits = ^{bus.Instr[31:26], rs_field, rt_field, rd_field};

  logic              valid_reg;
  logic [DATA_W-1:0] rf_a_reg, rf_b_reg, immed_reg;
  logic [AW-1:0]     wr_addr_reg, rs_reg, rb_reg;
  logic [1:0]        st_size_reg;

  assign rs_field = bus.Instr[RS_LSB +: FIELD_W];
  assign rt_field = bus.Instr[RT_LSB +: FIELD_W];
  assign rd_field = bus.Instr[RD_LSB +: FIELD_W];
  assign imm      = bus.Instr[IMM_LSB +: IMM_W];
  assign rs_addr  = rs_field[AW-1:0];
  assign rt_addr  = rt_field[AW-1:0];
  assign rb_addr  = bus.RF_B_sel ? rt_addr : rd_field[AW-1:0];

  assign wb_data  = bus.WB_Sel ? ld_ext(bus.MEM_out, bus.Ld_size, bus.Ld_signed)
                               : bus.ALU_out;
  assign wb_we    = bus.WB_WrEn && (bus.WB_Addr != '0);
  assign hit_rs   = wb_we && (bus.WB_Addr == rs_reg);
  assign hit_rb   = wb_we && (bus.WB_Addr == rb_reg);

  dec_stage_pipe_rf_bypass #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT)
  ) u_rf (
    .clk  (Clk),
    .rst  (Rst),
    .we   (bus.WB_WrEn),
    .wa   (bus.WB_Addr),
    .wd   (wb_data),
    .ra_a (rs_addr),
    .ra_b (rb_addr),
    .rd_a (rf_a),
    .rd_b (rf_b)
  );

  // ID/EX register: reset > flush > stall (with operand refresh) > load.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid_reg   <= 1'b0;
      rf_a_reg    <= '0;
      rf_b_reg    <= '0;
      immed_reg   <= '0;
      wr_addr_reg <= '0;
      st_size_reg <= '0;
      rs_reg      <= '0;
      rb_reg      <= '0;
    end else if (bus.Flush) begin
      valid_reg <= 1'b0;
    end else if (bus.Stall) begin
      if (hit_rs) rf_a_reg <= wb_data;
      if (hit_rb) rf_b_reg <= replicate(wb_data, st_size_reg);
    end else begin
      valid_reg   <= bus.In_Valid;
      rf_a_reg    <= rf_a;
      rf_b_reg    <= replicate(rf_b, bus.St_size);
      immed_reg   <= imm_gen(imm, bus.Imm_sel);
      wr_addr_reg <= rt_addr;
      st_size_reg <= bus.St_size;
      rs_reg      <= rs_addr;
      rb_reg      <= rb_addr;
    end
  end

  assign bus.Out_Valid   = valid_reg;
  assign bus.Out_RF_A    = rf_a_reg;
  assign bus.Out_RF_B    = rf_b_reg;
  assign bus.Out_Immed   = immed_reg;
  assign bus.Out_Wr_Addr = wr_addr_reg;
  assign bus.Out_St_size = st_size_reg;

endmodule
